booth_seq_mul: RTL and testbench
================================

// Module: booth_seq_mul
//
// PURPOSE
//  Parametrised iterative radix-4 Booth multiplier; sequential successor to the combinational mul_op.
//  Accepts WIDTH-bit operands on a start pulse and returns a 2*WIDTH-bit product after a fixed latency.
//  Supports signed and unsigned modes and holds the result on product until the next start.
//  Sits beside the ALU; the control unit waits on done before writing HI/LO from product.
//
// PARAMETERS
//  WIDTH   32   operand width; must be even and >= 4 (elaboration error otherwise)
//  N_ITER  derived = WIDTH/2 + 1; number of radix-4 Booth steps (not overridable)
//
// PORTS
//  Clock         in   1          rising-edge clock
//  clear_n       in   1          asynchronous, active-low reset
//  start         in   1          request; sampled on rising Clock when FSM is IDLE or DONE
//  signed_mode   in   1          1 = two's-complement operands, 0 = unsigned; sampled with start
//  multiplicand  in   WIDTH      operand A; sampled with start
//  multiplier    in   WIDTH      operand B; sampled with start
//  busy          out  1          high while the FSM is in RUN
//  done          out  1          single-cycle pulse; product valid from this cycle on
//  product       out  2*WIDTH    result register; holds its value until the next completion
//
// BEHAVIOUR
//  - Reset (clear_n=0, async): FSM=IDLE; busy=0, done=0, product=0, all internal registers=0.
//    Reset mid-operation aborts the operation; no done pulse; product returns to 0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -start-> RUN; DONE -start-> RUN; DONE -!start-> IDLE; RUN -(step count==N_ITER-1)-> DONE.
//  - Load (edge accepting start): A and B are extended to WIDTH+2 bits.
//    Extension is sign-extension if signed_mode=1, zero-extension if signed_mode=0.
//    The accumulator is cleared; the Booth pair bit B[-1]=0; step count=0.
//  - RUN, one step per cycle: recode the triplet {B[1],B[0],B[-1]} to {0,+A,+2A,-A,-2A}.
//    Add the recoded value to the upper accumulator half at WIDTH+3 bits.
//    Then arithmetic-shift {acc,B,B[-1]} right by 2 and increment the step count.
//  - Latency: with start accepted at edge k, done=1 during the cycle after edge k+N_ITER.
//    product is written on that same edge as the low 2*WIDTH bits of the result.
//    WIDTH=32 gives 17 RUN cycles.
//  - done is high exactly one cycle (DONE state). busy=1 only in RUN.
//  - start while RUN is ignored: operands are not re-sampled and the current operation is unaffected.
//  - start in DONE: a new operation is accepted back-to-back; done still pulses for the finished one.
//  - Operand inputs may change freely after the accepting edge.
//  - Arithmetic: results are exact for all inputs in both modes; no overflow flag.
//    Signed -2^(W-1) * -2^(W-1) = +2^(2W-2).
//
// CONFIGURATION
//  MUL_EARLY_EXIT_EN defined:
//    If either sampled operand is zero at the accepting edge, the FSM goes straight to DONE.
//    product=0 is written on that edge, so done arrives one cycle after acceptance; RUN is skipped.
//    All other operands keep the full N_ITER latency.
//  MUL_EARLY_EXIT_EN undefined: every operation takes N_ITER RUN cycles, including zero operands.
//
// TESTING (WIDTH=32; latency checked as 18 cycles start->done unless stated otherwise)
//  1. unsigned 0xFFFFFFFF*0xFFFFFFFF -> product=0xFFFFFFFE_00000001; done 1 cycle; busy 17 cycles.
//  2. signed -7*3 -> product=0xFFFFFFFF_FFFFFFEB; signed 0x80000000*0x80000000 -> 0x40000000_00000000.
//  3. signed -1*-1 -> 0x00000000_00000001.
//     Same operands in unsigned mode -> 0xFFFFFFFE_00000001.
//  4. start with 5*6, then pulse start with 9*9 at RUN step 4 -> product=30 (second start ignored).
//     Then issue start in the DONE cycle with 9*9 -> product=81 eighteen cycles later.
//  5. clear_n low at RUN step 10 of 12345*678 -> busy=0, done=0, product=0 immediately; no done pulse.
//     After release, 12345*678 -> 8369910.
//  6. 0*0xDEADBEEF: macro defined -> done 1 cycle after start, product=0, busy never 1.
//     Macro undefined -> done after 18 cycles, product=0.

Source files
------------

// File: rtl/booth_seq_mul.sv
// booth_seq_mul
//   Iterative radix-4 Booth multiplier. A start pulse samples two WIDTH-bit
//   operands (signed or unsigned); after N_ITER = WIDTH/2+1 Booth steps the
//   2*WIDTH-bit product is written to `product` and `done` pulses for one
//   cycle. `product` holds its value until the next completion.
//
//   Handshake: a request is accepted on any rising Clock edge where start=1
//   and the FSM is IDLE or DONE; start is ignored while busy=1. done=1 for
//   exactly one cycle, and product is valid from that cycle onward.
//
//   Optional feature (macro MUL_EARLY_EXIT_EN): when either operand is zero
//   at the accepting edge, product=0 is written on that edge and the FSM
//   goes directly to DONE, skipping RUN.
//
// Ports
//   Clock         in   rising-edge clock
//   clear_n       in   asynchronous active-low reset
//   start         in   request pulse
//   signed_mode   in   1 = two's complement operands, 0 = unsigned
//   multiplicand  in   operand A (WIDTH)
//   multiplier    in   operand B (WIDTH)
//   busy          out  high while in RUN
//   done          out  one-cycle completion pulse (DONE state)
//   product       out  result register (2*WIDTH)
//   dbg_state     out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module booth_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [1:0]         dbg_state
);

  localparam int N_ITER = WIDTH / 2 + 1;
  localparam int XW     = WIDTH + 2;          // extended operand width
  localparam int CW     = $clog2(N_ITER);     // step counter width

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_seq_mul: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next_state;

  logic [XW-1:0] r_a;      // extended multiplicand
  logic [XW-1:0] r_acc;    // upper accumulator half
  logic [XW-1:0] r_b;      // multiplier, shifted out as product low bits
  logic          r_bm1;    // Booth pair bit B[-1]
  logic [CW-1:0] r_cnt;

  logic          w_accept;
  logic          w_zero_op;
  logic          w_last;
  logic [XW:0]   w_a_x;
  logic [XW:0]   w_pp;
  logic [XW:0]   w_sum;
  logic [XW-1:0] w_next_acc;
  logic [XW-1:0] w_next_b;

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(N_ITER - 1));

`ifdef MUL_EARLY_EXIT_EN
  assign w_zero_op = (multiplicand == '0) || (multiplier == '0);
`else
  assign w_zero_op = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (start) w_next_state = w_zero_op ? S_DONE : S_RUN;
      S_RUN:  if (w_last) w_next_state = S_DONE;
      S_DONE: begin
        if (start) w_next_state = w_zero_op ? S_DONE : S_RUN;
        else       w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Booth recoding of {B[1],B[0],B[-1]} and one radix-4 step. The add is
  // done one bit wider than the accumulator so that +/-2A cannot overflow.
  always_comb begin
    w_a_x = {r_a[XW-1], r_a};
    case ({r_b[1:0], r_bm1})
      3'b001, 3'b010: w_pp = w_a_x;
      3'b011:         w_pp = {r_a, 1'b0};
      3'b100:         w_pp = -{r_a, 1'b0};
      3'b101, 3'b110: w_pp = -w_a_x;
      default:        w_pp = '0;
    endcase
    w_sum      = {r_acc[XW-1], r_acc} + w_pp;
    // Arithmetic shift of {sum, B, B[-1]} right by two.
    w_next_acc = {w_sum[XW], w_sum[XW:2]};
    w_next_b   = {w_sum[1:0], r_b[XW-1:2]};
  end

  // Datapath
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      r_a     <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_bm1   <= 1'b0;
      r_cnt   <= '0;
      product <= '0;
    end else if (w_accept) begin
      r_a   <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                           : {2'b00, multiplicand};
      r_b   <= signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                           : {2'b00, multiplier};
      r_acc <= '0;
      r_bm1 <= 1'b0;
      r_cnt <= '0;
      if (w_zero_op) product <= '0;
    end else if (r_state == S_RUN) begin
      r_acc <= w_next_acc;
      r_b   <= w_next_b;
      r_bm1 <= r_b[1];
      r_cnt <= r_cnt + CW'(1);
      // After the last step the B register holds the low WIDTH+2 product
      // bits and the accumulator the rest.
      if (w_last) product <= {w_next_acc[WIDTH-3:0], w_next_b};
    end
  end

endmodule

// File: tb/tb_booth_seq_mul.sv
module tb_booth_seq_mul;

  localparam int W      = 32;
  localparam int N_ITER = W / 2 + 1;
  localparam int LAT    = N_ITER + 1;   // accepting edge through done edge
  localparam int TMO    = 200;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          Clock;
  logic          clear_n;
  logic          start;
  logic          signed_mode;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  booth_seq_mul #(.WIDTH(W)) dut (
    .Clock        (Clock),
    .clear_n      (clear_n),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    return (EARLY && (a == '0 || b == '0)) ? 1 : LAT;
  endfunction

  function automatic int exp_busy(input logic [W-1:0] a, input logic [W-1:0] b);
    return (EARLY && (a == '0 || b == '0)) ? 0 : N_ITER;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1. Returns in the done cycle (posedge+1) or on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        output logic [2*W-1:0] prod, output int lat, output int busy_n,
                        output bit to);
    multiplicand = a;
    multiplier   = b;
    signed_mode  = s;
    start        = 1'b1;
    @(posedge Clock); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    signed_mode  = 1'($urandom_range(0, 1));
    lat    = 1;
    busy_n = 0;
    while (done !== 1'b1 && lat < TMO) begin
      if (busy === 1'b1) busy_n++;
      @(posedge Clock); #1;
      lat++;
    end
    to   = (done !== 1'b1);
    prod = product;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_n      = 1'b0;
    start        = 1'b1;
    signed_mode  = 1'b1;
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h9ABC_DEF0;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: busy=%b done=%b required busy=0 done=0", busy, done);
    end
    n_checks++;
    if (product !== '0) begin
      n_errors++;
      $display("FAIL reset_product: got %h required 0", product);
    end
    start = 1'b0;
    #2 clear_n = 1'b1;
    @(posedge Clock); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_errors++;
      $display("FAIL reset_idle: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
    end
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    bit             s;
    logic [2*W-1:0] e;
  } case_t;

  task automatic test_directed();
    case_t          cs[9];
    logic [2*W-1:0] p, e;
    int             lat, bn;
    bit             to;
    cs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    cs[1] = '{32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
    cs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    cs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
    cs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    cs[5] = '{32'd12345,     32'd678,       1'b0, 64'd8369910};
    cs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    cs[7] = '{32'h0000_0001, 32'h8000_0000, 1'b1, 64'hFFFF_FFFF_8000_0000};
    cs[8] = '{32'h0000_0001, 32'h8000_0000, 1'b0, 64'h0000_0000_8000_0000};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(cs[i].e);
      run_op(cs[i].a, cs[i].b, cs[i].s, p, lat, bn, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to) begin
        n_errors++;
        $display("FAIL directed%0d_timeout: no done within %0d cycles", i, TMO);
      end
      n_checks++;
      if (p !== e) begin
        n_errors++;
        $display("FAIL directed%0d_product: got %h required %h", i, p, e);
      end
      n_checks++;
      if (lat != LAT || bn != N_ITER) begin
        n_errors++;
        $display("FAIL directed%0d_timing: latency=%0d busy=%0d required %0d/%0d",
                 i, lat, bn, LAT, N_ITER);
      end
    end
    // done must be a single-cycle pulse
    @(posedge Clock); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL done_pulse: done=%b busy=%b one cycle after done, required 0/0", done, busy);
    end
  endtask

  task automatic test_random();
    logic [W-1:0]   a, b, corners[6];
    logic [2*W-1:0] p, e;
    bit             s, to;
    int             lat, bn, el, eb;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'h0000_0002;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
      s = 1'($urandom_range(0, 1));
      exp_q.push_back(ref_mul(a, b, s));
      el = exp_lat(a, b);
      eb = exp_busy(a, b);
      run_op(a, b, s, p, lat, bn, to);
      e = exp_q.pop_front();
      n_checks++;
      if (to || p !== e) begin
        n_errors++;
        $display("FAIL random%0d_product: %h*%h s=%0d got %h required %h timeout=%0d",
                 i, a, b, s, p, e, to);
      end
      n_checks++;
      if (lat != el || bn != eb) begin
        n_errors++;
        $display("FAIL random%0d_timing: latency=%0d busy=%0d required %0d/%0d",
                 i, lat, bn, el, eb);
      end
      // Alternate between back-to-back issue from DONE and issue from IDLE.
      if (i % 2 == 1) begin
        @(posedge Clock); #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // leave DONE so the first request starts from IDLE
    @(posedge Clock); #1;
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    lat   = 1;
    // pulse start with 9*9 at RUN step 4; it must be ignored
    repeat (4) begin
      @(posedge Clock); #1;
      lat++;
    end
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge Clock); #1;
    lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < TMO) begin
      @(posedge Clock); #1;
      lat++;
    end
    n_checks++;
    if (done !== 1'b1 || product !== 64'd30 || lat != LAT) begin
      n_errors++;
      $display("FAIL ignore_start: product=%0d latency=%0d required 30 / %0d", product, lat, LAT);
    end
    // issue 9*9 in the DONE cycle
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    lat   = 1;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || product !== 64'd30) begin
      n_errors++;
      $display("FAIL b2b_accept: busy=%b done=%b product=%0d required 1/0/30", busy, done, product);
    end
    while (done !== 1'b1 && lat < TMO) begin
      @(posedge Clock); #1;
      lat++;
    end
    n_checks++;
    if (done !== 1'b1 || product !== 64'd81 || lat != LAT) begin
      n_errors++;
      $display("FAIL b2b_result: product=%0d latency=%0d required 81 / %0d", product, lat, LAT);
    end
  endtask

  task automatic test_mid_reset();
    logic [2*W-1:0] p;
    int             lat, bn, seen;
    bit             to;
    @(posedge Clock); #1;
    multiplicand = 32'd12345;
    multiplier   = 32'd678;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    repeat (10) @(posedge Clock);
    #2 clear_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: busy=%b done=%b product=%h required 0/0/0", busy, done, product);
    end
    @(posedge Clock);
    #3 clear_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge Clock); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL mid_reset_abort: busy/done seen %0d cycles after abort, required 0", seen);
    end
    run_op(32'd12345, 32'd678, 1'b0, p, lat, bn, to);
    n_checks++;
    if (to || p !== 64'd8369910 || lat != LAT) begin
      n_errors++;
      $display("FAIL mid_reset_rerun: product=%0d latency=%0d required 8369910 / %0d", p, lat, LAT);
    end
  endtask

  task automatic test_zero_operand();
    logic [2*W-1:0] p;
    int             lat, bn;
    bit             to;
    @(posedge Clock); #1;
    run_op(32'h0, 32'hDEAD_BEEF, 1'b0, p, lat, bn, to);
    n_checks++;
    if (to || p !== '0 || lat != exp_lat(32'h0, 32'hDEAD_BEEF) || bn != exp_busy(32'h0, 32'h1)) begin
      n_errors++;
      $display("FAIL zero_a: product=%h latency=%0d busy=%0d required 0 / %0d / %0d",
               p, lat, bn, exp_lat(32'h0, 32'h1), exp_busy(32'h0, 32'h1));
    end
    // back-to-back zero operand after a non-zero product
    run_op(32'hFFFF_FFFF, 32'h3, 1'b1, p, lat, bn, to);
    run_op(32'hDEAD_BEEF, 32'h0, 1'b1, p, lat, bn, to);
    n_checks++;
    if (to || p !== '0 || lat != exp_lat(32'h1, 32'h0) || bn != exp_busy(32'h1, 32'h0)) begin
      n_errors++;
      $display("FAIL zero_b: product=%h latency=%0d busy=%0d required 0 / %0d / %0d",
               p, lat, bn, exp_lat(32'h1, 32'h0), exp_busy(32'h1, 32'h0));
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_mid_reset();
    test_zero_operand();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
